// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: frame-to-channel sequencer feeding a 1-to-8 demultiplexer.
// An 8-bit frame is accepted over valid/ready and presented bit-by-bit on D
// while sel steps through channels 0..7, each held for SLOT_CYCLES clocks.
// Optional feature: define DEMUX_SCAN_LOOP_EN to make an idle-ending scan
// restart on the held frame instead of returning to IDLE.
module demux_scan_ctrl #(
    parameter int SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       D,
    output logic [2:0] sel,
    output logic       EN,
    output logic       busy,
    output logic       frame_done
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [7:0]    frame_r;
    logic [7:0]    frame_s;
    logic [SW-1:0] slot_r;
    logic [SW-1:0] slot_s;
    logic [2:0]    sel_r;
    logic [2:0]    sel_s;
    logic          d_r;
    logic          d_s;
    logic          en_r;
    logic          en_s;
    logic          done_r;
    logic          done_s;
    logic          last_s;
    logic          ready_s;
    logic          accept_s;

    // The final cycle of channel 7 is the only scan cycle that can take a frame.
    assign last_s   = (state_r == SCAN) && (sel_r == 3'd7) && (slot_r == SLOT_LAST);
    assign ready_s  = (state_r == IDLE) || last_s;
    assign accept_s = din_valid && ready_s;

    assign din_ready  = ready_s;
    assign D          = d_r;
    assign sel        = sel_r;
    assign EN         = en_r;
    assign busy       = en_r;
    assign frame_done = done_r;

    // Next-state and next-output decode; outputs are derived from the next
    // state so that D/sel/EN/frame_done are all plain flops at the demux.
    always_comb begin
        state_s = state_r;
        frame_s = frame_r;
        slot_s  = slot_r;
        sel_s   = sel_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    frame_s = din;
                    slot_s  = {SW{1'b0}};
                    sel_s   = 3'd0;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    slot_s = {SW{1'b0}};
                    sel_s  = 3'd0;
                    if (accept_s) begin
                        frame_s = din;
                        state_s = SCAN;
                    end else begin
`ifdef DEMUX_SCAN_LOOP_EN
                        state_s = SCAN;
`else
                        state_s = IDLE;
`endif
                    end
                end else if (slot_r == SLOT_LAST) begin
                    slot_s = {SW{1'b0}};
                    sel_s  = sel_r + 3'd1;
                end else begin
                    slot_s = slot_r + SLOT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                slot_s  = {SW{1'b0}};
                sel_s   = 3'd0;
            end
        endcase

        en_s = (state_s == SCAN);
        if (en_s) begin
            d_s    = frame_s[sel_s];
            done_s = (sel_s == 3'd7) && (slot_s == SLOT_LAST);
        end else begin
            d_s    = 1'b0;
            done_s = 1'b0;
        end
    end

    // Scan FSM state, counters and registered demux-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            frame_r <= 8'd0;
            slot_r  <= {SW{1'b0}};
            sel_r   <= 3'd0;
            d_r     <= 1'b0;
            en_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            frame_r <= frame_s;
            slot_r  <= slot_s;
            sel_r   <= sel_s;
            d_r     <= d_s;
            en_r    <= en_s;
            done_r  <= done_s;
        end
    end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench for demux_scan_ctrl: two instances (SLOT_CYCLES=1 and 4)
// share a stimulus schedule. Each accepted frame expands into its full list of
// expected scan cycles (channel, bit, done flag); a monitor pops one entry per
// clock and compares it with the DUT outputs.
module tb_demux_scan_ctrl;

    typedef struct packed {
        logic [2:0] sel;
        logic       d;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din       [2] = '{8'd0, 8'd0};
    logic       din_valid [2] = '{1'b0, 1'b0};
    logic       din_ready [2];
    logic       D         [2];
    logic [2:0] sel       [2];
    logic       EN        [2];
    logic       busy      [2];
    logic       frame_done[2];

    int checks   = 0;
    int failures = 0;

    exp_t       eq [2][256];
    int         head [2] = '{0, 0};
    int         tail [2] = '{0, 0};
    logic [7:0] fr [2][64];
    int         fhead [2] = '{0, 0};
    int         ftail [2] = '{0, 0};
    logic [7:0] held [2] = '{8'd0, 8'd0};
    bit         looping [2] = '{1'b0, 1'b0};
    bit         force_valid = 1'b1;

    always #5 clk = ~clk;

    demux_scan_ctrl #(.SLOT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .D(D[0]), .sel(sel[0]), .EN(EN[0]),
        .busy(busy[0]), .frame_done(frame_done[0])
    );

    demux_scan_ctrl #(.SLOT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .D(D[1]), .sel(sel[1]), .EN(EN[1]),
        .busy(busy[1]), .frame_done(frame_done[1])
    );

    function automatic int slots(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [7:0] obs(int i);
        return {EN[i], busy[i], sel[i], D[i], frame_done[i], din_ready[i]};
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b (EN busy sel D done ready)",
                     name, $time, act, exp);
        end
    endtask

    // Expand one frame into every scan cycle it should produce.
    task automatic push_frame(int i, logic [7:0] f);
        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < slots(i); s++) begin
                eq[i][tail[i] % 256] = '{sel: 3'(k), d: f[k], fd: (k == 7 && s == slots(i) - 1)};
                tail[i]++;
            end
        end
    endtask

    task automatic add(int i, logic [7:0] f);
        fr[i][ftail[i] % 64] = f;
        ftail[i]++;
    endtask

    task automatic add_both(logic [7:0] f);
        add(0, f);
        add(1, f);
    endtask

    // Monitor: one comparison per DUT per clock, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    head[i] = tail[i];
                    chk($sformatf("d%0d_in_reset", i), obs(i), 8'b0000_0001);
                end else if (head[i] != tail[i]) begin
                    exp_t e;
                    e = eq[i][head[i] % 256];
                    head[i]++;
                    chk($sformatf("d%0d_scan", i), obs(i),
                        {2'b11, e.sel, e.d, e.fd, (head[i] == tail[i])});
                end else begin
                    chk($sformatf("d%0d_idle", i), obs(i), 8'b0000_0001);
                end
            end
        end
    end

    // Driver: present pending frames, and just before each edge decide from
    // the model whether the handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    fhead[i]     = ftail[i];
                    looping[i]   = 1'b0;
                    din_valid[i] = 1'b0;
                    din[i]       = 8'($urandom);
                end else if (fhead[i] == ftail[i]) begin
                    din_valid[i] = 1'b0;
                    din[i]       = 8'($urandom);
                end else begin
                    din[i] = fr[i][fhead[i] % 64];
                    if (!din_valid[i]) begin
                        din_valid[i] = force_valid || ($urandom_range(0, 2) == 0);
                    end
                end
            end
            #3;
            for (int i = 0; i < 2; i++) begin
                if (!rst && din_valid[i] && (head[i] == tail[i])) begin
                    push_frame(i, din[i]);
                    held[i]    = din[i];
                    looping[i] = 1'b1;
                    fhead[i]++;
                end
`ifdef DEMUX_SCAN_LOOP_EN
                else if (!rst && looping[i] && (head[i] == tail[i])) begin
                    push_frame(i, held[i]);
                end
`endif
            end
        end
    end

    function automatic bit pending();
        for (int i = 0; i < 2; i++) begin
            if (fhead[i] != ftail[i] || din_valid[i]) return 1'b1;
`ifndef DEMUX_SCAN_LOOP_EN
            if (head[i] != tail[i]) return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (pending() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL wait_idle timeout got=%0d cycles expected<3000", n);
        end
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_async_reset", i), obs(i), 8'b0000_0001);
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, then two back-to-back frames with valid held high.
        add_both(8'hA5);
        wait_idle();
        add_both(8'hA5);
        add_both(8'h3C);
        wait_idle();

        // Frame offered mid-scan must wait for the final slot.
        add_both(8'hA5);
        repeat (10) @(negedge clk);
        add_both(8'h81);
        wait_idle();

        // Reset mid-scan, then a fresh frame starts at channel 0.
        add_both(8'h5A);
        repeat (14) @(negedge clk);
        do_reset();
        add_both(8'hFF);
        wait_idle();

        // Randomised frames with random valid timing and gaps.
        force_valid = 1'b0;
        for (int n = 0; n < 30; n++) begin
            add_both(8'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if (n == 15) do_reset();
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
